lsu_rmw: RTL
============

Name: lsu_rmw

Overview:
- Load/store unit between the execute stage and the unified instruction/data memory. It drives the memory data port: word index, rmem code, wmem mask and store_data.
- Takes RISC-V byte-addressed loads and stores and performs them as whole-word reads and whole-word read-modify-write stores. The memory zero-fills unselected byte lanes on a store, so partial writes are never issued.
- Splits misaligned accesses into two word transactions.
- Stalls the core via done/busy until the access completes.

Parameters:
- ALLOW_MISALIGNED, 1, 1 = split word-crossing accesses; 0 = flag them as err with no memory access.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous, active-high reset
- req  input  1  access request; held by the core until done
- we  input  1  1 = store, 0 = load
- funct3  input  3  RISC-V width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- addr  input  32  byte address
- wdata  input  32  store data, right-justified
- rdata  output  32  load result, extended to 32 bits
- done  output  1  one-cycle completion pulse
- err  output  1  illegal access; valid with done
- busy  output  1  state not in {IDLE, DONE}
- mem_addr  output  32  memory word index
- rmem  output  5  memory read code; this block only issues 5'b01111 or 0
- wmem  output  4  memory write mask; this block only issues 4'b1111 or 0
- store_data  output  32  full merged word to write
- load_data  input  32  combinational memory read data

Behaviour:
- Reset (async, rst=1): state=IDLE, rdata=0, done=0, err=0. Memory-side outputs are 0. Any in-flight access is abandoned. A misaligned store interrupted after WR_LO leaves the low word written and the high word untouched.
- Memory-side outputs are combinational from state and the latched request. They are 0 in IDLE and DONE.
- Request is sampled only in IDLE. On req=1, latch addr, we, funct3 and wdata.
  - w0 = addr[31:2].
  - size = 1, 2 or 4 bytes.
  - cross = addr[1:0] + size > 4.
  - w1 = w0 + 1, modulo 2^30 (addr 0xFFFFFFFE wraps w1 to 0).
- Illegal access: load funct3 in {011, 110, 111}; store funct3 > 010; or cross with ALLOW_MISALIGNED=0. Illegal access goes IDLE -> DONE with err=1 and rdata=0.
- RD_LO: mem_addr=w0, rmem=01111. Capture load_data into lo.
  - Next: RD_HI if cross; else WR_LO if we; else DONE.
- RD_HI: mem_addr=w1, rmem=01111. Capture load_data into hi.
  - Next: WR_LO if we; else DONE.
- WR_LO: mem_addr=w0, wmem=1111. store_data = lo with bytes addr[1:0]..3 replaced by the low wdata bytes, little-endian.
  - Next: WR_HI if cross; else DONE.
- WR_HI: mem_addr=w1, wmem=1111. store_data = hi with its low bytes replaced by the remaining wdata bytes.
  - Next: DONE.
- rmem and wmem are never nonzero in the same cycle.
- Load result: the 64-bit pair {hi, lo} is shifted right by 8*addr[1:0], truncated to size, then sign- or zero-extended per funct3[2]. rdata is registered on entry to DONE and held until the next acceptance.
- DONE: done=1 for exactly one cycle, then IDLE. If req is still 1 in the cycle after done, it is accepted as a new access (back-to-back is allowed). The core stalls with req & ~done.
- Latency: cycle 1 is the first cycle after the acceptance edge. done is asserted in:
  - cycle 1: illegal access
  - cycle 2: aligned load
  - cycle 3: aligned store
  - cycle 3: misaligned load
  - cycle 5: misaligned store
- Request inputs are ignored outside IDLE.

Test Plan:
- Memory word 4 = 0xDEADBEEF; LW addr 0x10 -> done in cycle 2, rdata=0xDEADBEEF, wmem=0 throughout.
- LB addr 0x13 -> rdata=0xFFFFFFDE. LBU addr 0x13 -> 0x000000DE. LHU addr 0x12 -> 0x0000DEAD.
- SB addr 0x11, wdata 0x00000055 -> single write in cycle 2: mem_addr=4, wmem=1111, store_data=0xDEAD55EF; done in cycle 3.
- Words 4 = 0xDEADBEEF, 5 = 0x12345678; LW addr 0x12 -> reads of words 4 then 5, rdata=0x5678DEAD, done in cycle 3.
- SH addr 0x13, wdata 0xAABB -> word 4 = 0xBBADBEEF, word 5 = 0x123456AA, done in cycle 5.
- ALLOW_MISALIGNED=0 with the same SH -> done+err in cycle 1, no memory access.
- funct3=011 load -> done+err in cycle 1, no memory access.
- rst asserted during WR_HI of that SH -> all outputs 0 immediately, state IDLE, word 5 unchanged.

Source files
------------

// File: rtl/lsu_rmw.sv
// Load/store unit: byte-addressed loads/stores as whole-word reads and
// read-modify-write stores, splitting word-crossing accesses in two.
module lsu_rmw #(
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        done,
    output logic        err,
    output logic        busy,
    output logic [31:0] mem_addr,
    output logic [4:0]  rmem,
    output logic [3:0]  wmem,
    output logic [31:0] store_data,
    input  logic [31:0] load_data
);

    typedef enum logic [2:0] {
        IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, wdata_q, lo_q, hi_q, rdata_q;
    logic [2:0]  f3_q;
    logic        we_q, err_q;

    function automatic logic [2:0] size_of(input logic [1:0] f);
        unique case (f)
            2'b00:   size_of = 3'd1;
            2'b01:   size_of = 3'd2;
            default: size_of = 3'd4;
        endcase
    endfunction

    function automatic logic [3:0] lanes_of(input logic [1:0] f);
        unique case (f)
            2'b00:   lanes_of = 4'b0001;
            2'b01:   lanes_of = 4'b0011;
            default: lanes_of = 4'b1111;
        endcase
    endfunction

    logic cross_in, illegal_in, cross_q;

    assign cross_in = ({1'b0, addr[1:0]} + size_of(funct3[1:0])) > 3'd4;
    assign cross_q  = ({1'b0, addr_q[1:0]} + size_of(f3_q[1:0])) > 3'd4;

    always_comb begin
        illegal_in = 1'b0;
        if (we) begin
            illegal_in = funct3 > 3'b010;
        end else begin
            illegal_in = (funct3 == 3'b011) || (funct3 == 3'b110) ||
                         (funct3 == 3'b111);
        end
        if (cross_in && !ALLOW_MISALIGNED) begin
            illegal_in = 1'b1;
        end
    end

    // Word indices of the two halves; w1 wraps within the 30-bit space
    logic [29:0] w0, w1;
    assign w0 = addr_q[31:2];
    assign w1 = w0 + 30'd1;

    // Store merge over the {hi, lo} word pair
    logic [7:0]  bmask;
    logic [63:0] bitmask, data64, merged;

    always_comb begin
        bmask   = {4'b0000, lanes_of(f3_q[1:0])} << addr_q[1:0];
        data64  = 64'(wdata_q) << {addr_q[1:0], 3'b000};
        bitmask = '0;
        for (int i = 0; i < 8; i++) begin
            bitmask[i*8 +: 8] = {8{bmask[i]}};
        end
        merged = ({hi_q, lo_q} & ~bitmask) | (data64 & bitmask);
    end

    // Load extract uses the word being read this cycle, not yet registered
    logic [31:0] lo_v, hi_v, sh, ld_res;

    always_comb begin
        lo_v = (state_q == RD_LO) ? load_data : lo_q;
        hi_v = (state_q == RD_HI) ? load_data : hi_q;
        sh   = 32'({hi_v, lo_v} >> {addr_q[1:0], 3'b000});
        unique case (f3_q[1:0])
            2'b00:   ld_res = f3_q[2] ? {24'b0, sh[7:0]}
                                      : {{24{sh[7]}}, sh[7:0]};
            2'b01:   ld_res = f3_q[2] ? {16'b0, sh[15:0]}
                                      : {{16{sh[15]}}, sh[15:0]};
            default: ld_res = sh;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (req) state_d = illegal_in ? DONE : RD_LO;
            RD_LO:   state_d = cross_q ? RD_HI : (we_q ? WR_LO : DONE);
            RD_HI:   state_d = we_q ? WR_LO : DONE;
            WR_LO:   state_d = cross_q ? WR_HI : DONE;
            WR_HI:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_addr   = '0;
        rmem       = '0;
        wmem       = '0;
        store_data = '0;
        unique case (state_q)
            RD_LO: begin
                mem_addr = {2'b00, w0};
                rmem     = 5'b01111;
            end
            RD_HI: begin
                mem_addr = {2'b00, w1};
                rmem     = 5'b01111;
            end
            WR_LO: begin
                mem_addr   = {2'b00, w0};
                wmem       = 4'b1111;
                store_data = merged[31:0];
            end
            WR_HI: begin
                mem_addr   = {2'b00, w1};
                wmem       = 4'b1111;
                store_data = merged[63:32];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
            f3_q    <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            lo_q    <= '0;
            hi_q    <= '0;
            rdata_q <= '0;
        end else begin
            if (state_q == IDLE && req) begin
                addr_q  <= addr;
                wdata_q <= wdata;
                f3_q    <= funct3;
                we_q    <= we;
                err_q   <= illegal_in;
            end
            if (state_q == RD_LO) lo_q <= load_data;
            if (state_q == RD_HI) hi_q <= load_data;
            if (state_d == DONE && state_q != DONE) begin
                rdata_q <= (state_q == IDLE || we_q) ? 32'd0 : ld_res;
            end
        end
    end

    assign done  = state_q == DONE;
    assign err   = done & err_q;
    assign busy  = (state_q != IDLE) && (state_q != DONE);
    assign rdata = rdata_q;

endmodule
